// File: rtl/sp_fifo_pkg.sv
// Shared types and default sizes for the sp_fifo arbitration controller.
// Optional statistics counters are enabled with SP_FIFO_ARB_STATS_EN.
package sp_fifo_pkg;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 16;
   localparam int CW_DEF    = 5;

   typedef enum logic {
      GNT_P0 = 1'b0,
      GNT_P1 = 1'b1
   } grant_t;

   typedef logic [DW_DEF-1:0] data_t;

   localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/sp_fifo_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last grant is remembered only when
// the caller reports that the grant was actually used.
module rr_arb2
   import sp_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   grant_t r_last;

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (r_last == GNT_P0) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Reset to P1 so that P0 wins the first contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= GNT_P1;
      end else if (advance) begin
         r_last <= gnt[1] ? GNT_P1 : GNT_P0;
      end
   end

endmodule

// File: rtl/sp_fifo_arb_ctrl.sv
// Flag/arbitration controller in front of a flagless 16x8 sp_fifo.
// Define SP_FIFO_ARB_STATS_EN to add wr_cnt0/wr_cnt1/ovf_cnt outputs.
module sp_fifo_arb_ctrl
   import sp_fifo_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_valid,
   input  logic [DW-1:0] p0_data,
   output logic          p0_ready,
   input  logic          p1_valid,
   input  logic [DW-1:0] p1_data,
   output logic          p1_ready,
   input  logic          c_req,
   output logic [DW-1:0] c_data,
   output logic          c_valid,
   output logic          fifo_wr_en,
   output logic [DW-1:0] fifo_din,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_dout,
`ifdef SP_FIFO_ARB_STATS_EN
   output logic [15:0]   wr_cnt0,
   output logic [15:0]   wr_cnt1,
   output logic [15:0]   ovf_cnt,
`endif
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   logic [CW-1:0] r_count;
   logic          r_c_valid;
   logic          w_full;
   logic          w_empty;
   logic [1:0]    w_req;
   logic [1:0]    w_gnt;
   logic          w_wr;
   logic          w_rd;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // A full FIFO takes no write even if a read frees a slot this cycle.
   assign w_req = {p1_valid, p0_valid} & {2{rst_n & ~w_full}};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_req),
      .advance (w_wr),
      .gnt     (w_gnt)
   );

   assign w_wr = |w_gnt;
   assign w_rd = rst_n & c_req & ~w_empty;

   assign p0_ready   = w_gnt[0];
   assign p1_ready   = w_gnt[1];
   assign fifo_wr_en = w_wr;
   assign fifo_din   = w_gnt[1] ? p1_data : p0_data;
   assign fifo_rd_en = w_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_c_valid <= 1'b0;
      end else begin
         r_c_valid <= w_rd;
         unique case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign count   = r_count;
   assign full    = w_full;
   assign empty   = w_empty;
   assign c_valid = r_c_valid;
   assign c_data  = fifo_dout;

`ifdef SP_FIFO_ARB_STATS_EN
   logic [15:0] r_wr_cnt0;
   logic [15:0] r_wr_cnt1;
   logic [15:0] r_ovf_cnt;
   logic        w_ovf;

   assign w_ovf = w_full & (p0_valid | p1_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt0 <= '0;
         r_wr_cnt1 <= '0;
         r_ovf_cnt <= '0;
      end else begin
         if (w_gnt[0] && r_wr_cnt0 != STAT_MAX) begin
            r_wr_cnt0 <= r_wr_cnt0 + 16'd1;
         end
         if (w_gnt[1] && r_wr_cnt1 != STAT_MAX) begin
            r_wr_cnt1 <= r_wr_cnt1 + 16'd1;
         end
         if (w_ovf && r_ovf_cnt != STAT_MAX) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
         end
      end
   end

   assign wr_cnt0 = r_wr_cnt0;
   assign wr_cnt1 = r_wr_cnt1;
   assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_sp_fifo_arb_ctrl.sv
// Directed bench for sp_fifo_arb_ctrl with a behavioural sp_fifo and a
// scoreboard of expected read data (stats checked if SP_FIFO_ARB_STATS_EN).
module tb_sp_fifo_arb_ctrl;

   logic       clk;
   logic       rst_n;
   logic       p0_valid, p1_valid;
   logic [7:0] p0_data, p1_data;
   logic       p0_ready, p1_ready;
   logic       c_req;
   logic [7:0] c_data;
   logic       c_valid;
   logic       fifo_wr_en, fifo_rd_en;
   logic [7:0] fifo_din, fifo_dout;
   logic [4:0] count;
   logic       full, empty;
`ifdef SP_FIFO_ARB_STATS_EN
   logic [15:0] wr_cnt0, wr_cnt1, ovf_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   sp_fifo_arb_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p0_valid   (p0_valid),
      .p0_data    (p0_data),
      .p0_ready   (p0_ready),
      .p1_valid   (p1_valid),
      .p1_data    (p1_data),
      .p1_ready   (p1_ready),
      .c_req      (c_req),
      .c_data     (c_data),
      .c_valid    (c_valid),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
`ifdef SP_FIFO_ARB_STATS_EN
      .wr_cnt0    (wr_cnt0),
      .wr_cnt1    (wr_cnt1),
      .ovf_cnt    (ovf_cnt),
`endif
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flagless FIFO with one-cycle read latency, sharing rst_n.
   logic [7:0] mem [16];
   logic [3:0] wp, rp;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         fifo_dout <= '0;
      end else begin
         if (fifo_wr_en) begin
            mem[wp] <= fifo_din;
            wp <= wp + 4'd1;
         end
         if (fifo_rd_en) begin
            fifo_dout <= mem[rp];
            rp <= rp + 4'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Single-producer write that must be accepted this cycle.
   task automatic put(input int who, input logic [7:0] d);
      p0_valid = (who == 0);
      p1_valid = (who == 1);
      if (who == 0) p0_data = d;
      else          p1_data = d;
      #3;
      chk("put_p0_ready", p0_ready, (who == 0));
      chk("put_p1_ready", p1_ready, (who == 1));
      chk("put_din", fifo_din, d);
      exp_q.push_back(d);
      cyc();
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && c_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: got %0h expected no data", c_data);
         end else begin
            chk("sb_data", c_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      p0_valid = 1'b1;
      p1_valid = 1'b1;
      p0_data = 8'h00;
      p1_data = 8'h00;
      c_req = 1'b1;
      #12;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_p0_ready", p0_ready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      c_req = 1'b0;
      rst_n = 1'b1;
      cyc();

      put(0, 8'h11);
      chk("t1_count", count, 1);
      chk("t1_empty", empty, 0);
      put(1, 8'h22);

      p0_valid = 1'b1; p0_data = 8'h11;
      p1_valid = 1'b1; p1_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("rr_p0_ready", p0_ready, (i % 2 == 0));
         chk("rr_p1_ready", p1_ready, (i % 2 == 1));
         exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
         cyc();
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      chk("rr_count", count, 6);

      for (int i = 0; i < 10; i++) put(0, 8'h80 + 8'(i));
      chk("fill_count", count, 16);
      chk("fill_full", full, 1);
      chk("fill_empty", empty, 0);
`ifdef SP_FIFO_ARB_STATS_EN
      chk("wr_cnt0", wr_cnt0, 13);
      chk("wr_cnt1", wr_cnt1, 3);
`endif

      p0_valid = 1'b1; p0_data = 8'hEE;
      #3;
      chk("ovf_p0_ready", p0_ready, 0);
      chk("ovf_wr_en", fifo_wr_en, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
`ifdef SP_FIFO_ARB_STATS_EN
         chk("ovf_cnt", ovf_cnt, k + 1);
`endif
         chk("ovf_count", count, 16);
         #3;
         chk("ovf_p0_ready", p0_ready, 0);
      end
      p0_valid = 1'b0;

      cyc();
      c_req = 1'b1;
      p1_valid = 1'b1; p1_data = 8'h33;
      #3;
      chk("fr_rd_en", fifo_rd_en, 1);
      chk("fr_p1_ready", p1_ready, 0);
      chk("fr_wr_en", fifo_wr_en, 0);
      cyc();
      c_req = 1'b0;
      chk("fr_count", count, 15);
      chk("fr_full", full, 0);
      #3;
      chk("fr_p1_ready2", p1_ready, 1);
      exp_q.push_back(8'h33);
      cyc();
      p1_valid = 1'b0;
      chk("fr_count2", count, 16);

      c_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #3;
         chk("drain_rd_en", fifo_rd_en, 1);
         cyc();
      end
      chk("drain_count", count, 0);
      chk("drain_empty", empty, 1);

      p0_valid = 1'b1; p0_data = 8'h5A;
      #3;
      chk("er_rd_en", fifo_rd_en, 0);
      chk("er_p0_ready", p0_ready, 1);
      exp_q.push_back(8'h5A);
      cyc();
      p0_valid = 1'b0;
      chk("er_c_valid", c_valid, 0);
      chk("er_count", count, 1);
      #3;
      chk("er_rd_en2", fifo_rd_en, 1);
      cyc();
      c_req = 1'b0;
      chk("er_c_valid2", c_valid, 1);
      chk("er_c_data", c_data, 8'h5A);
      cyc();

      for (int i = 0; i < 7; i++) put(0, 8'h70 + 8'(i));
      chk("mr_count", count, 7);
      c_req = 1'b1;
      #3;
      chk("mr_rd_en", fifo_rd_en, 1);
      cyc();
      c_req = 1'b0;
      chk("mr_c_valid", c_valid, 1);
      chk("mr_count2", count, 6);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_rst_count", count, 0);
      chk("mr_rst_empty", empty, 1);
      chk("mr_rst_c_valid", c_valid, 0);
      exp_q.delete();
      #5;
      rst_n = 1'b1;
      cyc();
      chk("mr_post_count", count, 0);
`ifdef SP_FIFO_ARB_STATS_EN
      chk("mr_post_ovf", ovf_cnt, 0);
`endif

      p0_valid = 1'b1; p0_data = 8'h99;
      p1_valid = 1'b1; p1_data = 8'hAA;
      #3;
      chk("pr_p0_ready", p0_ready, 1);
      chk("pr_p1_ready", p1_ready, 0);
      exp_q.push_back(8'h99);
      cyc();
      #3;
      chk("pr_p1_ready2", p1_ready, 1);
      exp_q.push_back(8'hAA);
      cyc();
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      c_req = 1'b1;
      cyc();
      cyc();
      c_req = 1'b0;
      cyc();
      cyc();
      chk("end_count", count, 0);
      chk("end_sb_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
